prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 172 +++++++++++++++++
 tb/tb_prbs_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for x^N + x^TAP + 1 with SEED/SYNC/LOCKED acquisition.
// Define PRBS_CHECKER_BIT_CNT_EN to add the bit_cnt output (locked valid bits, for BER).
module prbs_checker #(
  parameter int N        = 3,
  parameter int TAP      = 2,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_ERR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err,
`ifdef PRBS_CHECKER_BIT_CNT_EN
  output logic [CNT_W-1:0] bit_cnt,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FILL_W = $clog2(N + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_ERR + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_FULL  = BAD_W'(LOSS_ERR);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [N:1]          r_reg, r_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [GOOD_W-1:0]   good_reg, good_next;
  logic [BAD_W-1:0]    bad_reg, bad_next;
  logic                err_reg, err_next;
  logic [CNT_W-1:0]    err_cnt_reg, err_cnt_next;

  logic                exp_bit;
  logic                match;
  logic [N:2]          r_aged;
  logic [N:1]          r_shift_din;
  logic [N:1]          r_shift_exp;

  assign exp_bit = r_reg[TAP] ^ r_reg[N];
  assign match   = (din == exp_bit);

  // Stage k takes stage k-1; stage 1 is loaded with the incoming (or predicted) bit.
  for (genvar gi = 2; gi <= N; gi++) begin : g_age
    assign r_aged[gi] = r_reg[gi-1];
  end

  assign r_shift_din = {r_aged, din};
  assign r_shift_exp = {r_aged, exp_bit};

  always_comb begin
    state_next   = state_reg;
    r_next       = r_reg;
    fill_next    = fill_reg;
    good_next    = good_reg;
    bad_next     = bad_reg;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;

    if (din_valid) begin
      unique case (state_reg)
        ST_SEED: begin
          r_next = r_shift_din;
          if (fill_reg != FILL_FULL) begin
            fill_next = fill_reg + FILL_W'(1);
          end
          if ((fill_next == FILL_FULL) && (r_next != '0)) begin
            state_next = ST_SYNC;
          end
        end

        ST_SYNC: begin
          r_next = r_shift_din;
          if (match) begin
            good_next = good_reg + GOOD_W'(1);
            if (good_next == GOOD_FULL) begin
              state_next = ST_LOCKED;
            end
          end else begin
            good_next = '0;
          end
        end

        ST_LOCKED: begin
          // Feed back the prediction so a corrupted bit cannot poison later predictions.
          r_next = r_shift_exp;
          if (!match) begin
            err_next = 1'b1;
            bad_next = bad_reg + BAD_W'(1);
            if (bad_next == BAD_FULL) begin
              state_next = ST_SEED;
              fill_next  = '0;
              good_next  = '0;
              bad_next   = '0;
            end
          end else begin
            bad_next = '0;
          end
        end

        default: begin
          state_next = ST_SEED;
        end
      endcase
    end

    if (clear_cnt) begin
      err_cnt_next = '0;
    end else if (err_next && (err_cnt_reg != '1)) begin
      err_cnt_next = err_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_SEED;
      r_reg       <= '0;
      fill_reg    <= '0;
      good_reg    <= '0;
      bad_reg     <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      r_reg       <= r_next;
      fill_reg    <= fill_next;
      good_reg    <= good_next;
      bad_reg     <= bad_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

`ifdef PRBS_CHECKER_BIT_CNT_EN
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (clear_cnt) begin
      bit_cnt_next = '0;
    end else if (din_valid && (state_reg == ST_LOCKED) && (bit_cnt_reg != '1)) begin
      bit_cnt_next = bit_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign bit_cnt = bit_cnt_reg;
`endif

  assign locked  = (state_reg == ST_LOCKED);
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a CNT_W=16 instance plus a CNT_W=4 instance for saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset, din, din_valid, clear_cnt;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic        locked4, err4;
  logic [3:0]  err_cnt4;
`ifdef PRBS_CHECKER_BIT_CNT_EN
  logic [15:0] bit_cnt;
  logic [3:0]  bit_cnt4;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int ph      = 0;
  logic [0:6] ref_pat = 7'b1011100;

  always #5 clk = ~clk;

  prbs_checker #(.N(3), .TAP(2), .LOCK_CNT(8), .LOSS_ERR(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err(err),
`ifdef PRBS_CHECKER_BIT_CNT_EN
    .bit_cnt(bit_cnt),
`endif
    .err_cnt(err_cnt)
  );

  prbs_checker #(.N(3), .TAP(2), .LOCK_CNT(8), .LOSS_ERR(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked4), .err(err4),
`ifdef PRBS_CHECKER_BIT_CNT_EN
    .bit_cnt(bit_cnt4),
`endif
    .err_cnt(err_cnt4)
  );

  task automatic step(input logic b, input logic v, input logic c);
    din = b; din_valid = v; clear_cnt = c;
    @(posedge clk); #1;
  endtask

  task automatic send_ref(input logic inv);
    step(ref_pat[ph] ^ inv, 1'b1, 1'b0);
    ph = (ph + 1) % 7;
  endtask

  task automatic do_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ph = 0;
  endtask

  task automatic lock_up(input string tag);
    do_reset();
    repeat (11) send_ref(1'b0);
    n_total++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL %s lock_up: locked=%b want 1", tag, locked);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0;
    #2;
    n_total += 3;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send_ref(1'b0);
      n_total++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL lock_err bit %0d: got %b want 0", i, err); end
      if (i == 10 || i == 11 || i == 100) begin
        n_total++;
        if (locked !== (i >= 11)) begin
          n_bad++; $display("FAIL lock_locked bit %0d: got %b want %b", i, locked, (i >= 11));
        end
      end
    end
    n_total++;
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); end
`ifdef PRBS_CHECKER_BIT_CNT_EN
    n_total++;
    if (bit_cnt !== 16'd89) begin n_bad++; $display("FAIL lock_bit_cnt: got %0d want 89", bit_cnt); end
`endif
    $display("test_lock: 100 reference bits, err_cnt=%0d", err_cnt);
  endtask

  task automatic test_single_err();
    lock_up("single");
    send_ref(1'b1);
    n_total += 3;
    if (err !== 1'b1) begin n_bad++; $display("FAIL single_err_pulse: got %b want 1", err); end
    if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %b want 1", locked); end
    for (int i = 1; i <= 10; i++) begin
      send_ref(1'b0);
      n_total += 2;
      if (err !== 1'b0) begin n_bad++; $display("FAIL single_after_err bit %0d: got %b want 0", i, err); end
      if (locked !== 1'b1) begin n_bad++; $display("FAIL single_after_locked bit %0d: got %b want 1", i, locked); end
    end
    n_total++;
    if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL single_final_cnt: got %0d want 1", err_cnt); end
    $display("test_single_err: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_loss();
    lock_up("loss");
    for (int k = 1; k <= 4; k++) begin
      send_ref(1'b1);
      n_total += 2;
      if (err !== 1'b1) begin n_bad++; $display("FAIL loss_err k=%0d: got %b want 1", k, err); end
      if (locked !== (k < 4)) begin
        n_bad++; $display("FAIL loss_locked k=%0d: got %b want %b", k, locked, (k < 4));
      end
    end
    n_total++;
    if (err_cnt !== 16'd4) begin n_bad++; $display("FAIL loss_err_cnt: got %0d want 4", err_cnt); end
    for (int i = 1; i <= 11; i++) begin
      send_ref(1'b0);
      n_total += 2;
      if (err !== 1'b0) begin n_bad++; $display("FAIL relock_err bit %0d: got %b want 0", i, err); end
      if (locked !== (i == 11)) begin
        n_bad++; $display("FAIL relock_locked bit %0d: got %b want %b", i, locked, (i == 11));
      end
    end
    $display("test_loss: err_cnt=%0d relocked=%b", err_cnt, locked);
  endtask

  task automatic test_zero_idle();
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_total++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL zero_locked cyc %0d: got %b want 0", i, locked); end
    end
    do_reset();
    for (int v = 1; v <= 11; v++) begin
      send_ref(1'b0);
      n_total++;
      if (locked !== (v == 11)) begin
        n_bad++; $display("FAIL idle_locked valid %0d: got %b want %b", v, locked, (v == 11));
      end
      step(~ref_pat[ph], 1'b0, 1'b0);
      n_total++;
      if (locked !== (v == 11)) begin
        n_bad++; $display("FAIL idle_hold valid %0d: got %b want %b", v, locked, (v == 11));
      end
    end
    $display("test_zero_idle: locked=%b", locked);
  endtask

  task automatic test_saturation();
    lock_up("sat");
    for (int k = 1; k <= 20; k++) begin
      send_ref(1'b1);
      n_total += 2;
      if (err_cnt !== 16'(k)) begin n_bad++; $display("FAIL sat_cnt16 k=%0d: got %0d want %0d", k, err_cnt, k); end
      if (err_cnt4 !== 4'((k > 15) ? 15 : k)) begin
        n_bad++; $display("FAIL sat_cnt4 k=%0d: got %0d want %0d", k, err_cnt4, (k > 15) ? 15 : k);
      end
      send_ref(1'b0);
    end
    n_total += 2;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b want 1", locked); end
    if (locked4 !== 1'b1) begin n_bad++; $display("FAIL sat_locked4: got %b want 1", locked4); end
    step(ref_pat[ph] ^ 1'b1, 1'b1, 1'b1);
    ph = (ph + 1) % 7;
    n_total += 3;
    if (err !== 1'b1) begin n_bad++; $display("FAIL clr_err: got %b want 1", err); end
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_cnt16: got %0d want 0", err_cnt); end
    if (err_cnt4 !== 4'd0) begin n_bad++; $display("FAIL clr_cnt4: got %0d want 0", err_cnt4); end
    $display("test_saturation: cleared err_cnt=%0d err_cnt4=%0d", err_cnt, err_cnt4);
  endtask

  task automatic test_reset_mid_lock();
    lock_up("midrst");
    send_ref(1'b1);
    #2;
    reset = 1'b1;
    #1;
    n_total += 3;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked: got %b want 0", locked); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", err); end
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
`ifdef PRBS_CHECKER_BIT_CNT_EN
    n_total++;
    if (bit_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_bit_cnt: got %0d want 0", bit_cnt); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    ph = 0;
    for (int i = 1; i <= 11; i++) begin
      send_ref(1'b0);
      if (i >= 10) begin
        n_total++;
        if (locked !== (i == 11)) begin
          n_bad++; $display("FAIL midrst_relock bit %0d: got %b want %b", i, locked, (i == 11));
        end
      end
    end
    n_total++;
    if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_final_cnt: got %0d want 0", err_cnt); end
    $display("test_reset_mid_lock: relocked=%b err_cnt=%0d", locked, err_cnt);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_loss();
    test_zero_idle();
    test_saturation();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
